cache_stat_counters: RTL and testbench

- Accumulates the cache event counts that feed the statistics printer.
- Seven saturating counters are incremented by single-cycle event strobes from the instruction- and data-cache controllers.
- Trace-level commands clear the counters and request a printout.
- Drives the printer's count inputs continuously and generates its rising-edge print trigger through a small window FSM.

---
 rtl/cache_stats_pkg.sv | 16 +
 rtl/sat_counter.sv | 36 +++
 rtl/cache_stat_counters.sv | 101 ++++++++++
 tb/tb_cache_stat_counters.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cache_stats_pkg.sv
// Shared types and constants for the cache statistics counter block.
package cache_stats_pkg;

    // Default width of every statistics counter.
    localparam int unsigned COUNT_W_DFLT = 32;

    typedef logic [COUNT_W_DFLT-1:0] count_t;

    // Print-trigger window FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_PRINT = 2'd2
    } print_state_e;

endpackage : cache_stats_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/cache_stat_counters.sv
// Cache event statistics: seven saturating counters plus a print-trigger
// window FSM (IDLE -> ARM -> PRINT x PRINT_WIDTH -> IDLE).
module cache_stat_counters
    import cache_stats_pkg::*;
#(
    parameter int unsigned COUNT_W     = COUNT_W_DFLT,
    parameter int unsigned PRINT_WIDTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ins_read_ev,
    input  logic               ins_hit_ev,
    input  logic               ins_miss_ev,
    input  logic               data_read_ev,
    input  logic               data_write_ev,
    input  logic               data_hit_ev,
    input  logic               data_miss_ev,
    input  logic               clear,
    input  logic               print_req,
    output logic [COUNT_W-1:0] ins_reads,
    output logic [COUNT_W-1:0] ins_hit,
    output logic [COUNT_W-1:0] ins_miss,
    output logic [COUNT_W-1:0] data_reads,
    output logic [COUNT_W-1:0] data_writes,
    output logic [COUNT_W-1:0] data_hit,
    output logic [COUNT_W-1:0] data_miss,
    output logic               print,
    output logic               busy
);

    sat_counter #(.W(COUNT_W)) u_ins_reads (
        .clk(clk), .reset(reset), .clr(clear), .inc(ins_read_ev), .count(ins_reads)
    );
    sat_counter #(.W(COUNT_W)) u_ins_hit (
        .clk(clk), .reset(reset), .clr(clear), .inc(ins_hit_ev), .count(ins_hit)
    );
    sat_counter #(.W(COUNT_W)) u_ins_miss (
        .clk(clk), .reset(reset), .clr(clear), .inc(ins_miss_ev), .count(ins_miss)
    );
    sat_counter #(.W(COUNT_W)) u_data_reads (
        .clk(clk), .reset(reset), .clr(clear), .inc(data_read_ev), .count(data_reads)
    );
    sat_counter #(.W(COUNT_W)) u_data_writes (
        .clk(clk), .reset(reset), .clr(clear), .inc(data_write_ev), .count(data_writes)
    );
    sat_counter #(.W(COUNT_W)) u_data_hit (
        .clk(clk), .reset(reset), .clr(clear), .inc(data_hit_ev), .count(data_hit)
    );
    sat_counter #(.W(COUNT_W)) u_data_miss (
        .clk(clk), .reset(reset), .clr(clear), .inc(data_miss_ev), .count(data_miss)
    );

    print_state_e state_q;
    print_state_e state_d;
    logic [3:0]   win_q;
    logic [3:0]   win_d;

    // State and window-counter registers; reset aborts any window in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
        end
    end

    // Next-state and Moore outputs; requests are only accepted in IDLE.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        print   = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (print_req) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                busy    = 1'b1;
                state_d = ST_PRINT;
                win_d   = 4'(PRINT_WIDTH);
            end
            ST_PRINT: begin
                busy  = 1'b1;
                print = 1'b1;
                if (win_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    win_d = win_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule : cache_stat_counters

// File: tb/tb_cache_stat_counters.sv
// Directed self-checking bench for cache_stat_counters: a 32-bit instance
// with a 2-cycle print window and a 4-bit instance with a 1-cycle window.
module tb_cache_stat_counters;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic ir = 0, ih = 0, im = 0, dr = 0, dw = 0, dh = 0, dm = 0;
    logic clr = 0, preq = 0;
    logic [31:0] o_ir, o_ih, o_im, o_dr, o_dw, o_dh, o_dm;
    logic o_print, o_busy;

    logic w_dw = 0, w_req = 0;
    logic [3:0] w_ir, w_ih, w_im, w_dr, w_dw_cnt, w_dh, w_dm;
    logic w_print, w_busy;

    int errors = 0;
    int checks = 0;

    cache_stat_counters #(.COUNT_W(32), .PRINT_WIDTH(2)) dut (
        .clk(clk), .reset(reset),
        .ins_read_ev(ir), .ins_hit_ev(ih), .ins_miss_ev(im),
        .data_read_ev(dr), .data_write_ev(dw), .data_hit_ev(dh), .data_miss_ev(dm),
        .clear(clr), .print_req(preq),
        .ins_reads(o_ir), .ins_hit(o_ih), .ins_miss(o_im),
        .data_reads(o_dr), .data_writes(o_dw), .data_hit(o_dh), .data_miss(o_dm),
        .print(o_print), .busy(o_busy)
    );

    cache_stat_counters #(.COUNT_W(4), .PRINT_WIDTH(1)) dut4 (
        .clk(clk), .reset(reset),
        .ins_read_ev(1'b0), .ins_hit_ev(1'b0), .ins_miss_ev(1'b0),
        .data_read_ev(1'b0), .data_write_ev(w_dw), .data_hit_ev(1'b0), .data_miss_ev(1'b0),
        .clear(1'b0), .print_req(w_req),
        .ins_reads(w_ir), .ins_hit(w_ih), .ins_miss(w_im),
        .data_reads(w_dr), .data_writes(w_dw_cnt), .data_hit(w_dh), .data_miss(w_dm),
        .print(w_print), .busy(w_busy)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] v);
        chk({tag, ".ins_reads"},   64'(o_ir), 64'(v));
        chk({tag, ".ins_hit"},     64'(o_ih), 64'(v));
        chk({tag, ".ins_miss"},    64'(o_im), 64'(v));
        chk({tag, ".data_reads"},  64'(o_dr), 64'(v));
        chk({tag, ".data_writes"}, 64'(o_dw), 64'(v));
        chk({tag, ".data_hit"},    64'(o_dh), 64'(v));
        chk({tag, ".data_miss"},   64'(o_dm), 64'(v));
    endtask

    logic exp_p[4];
    logic exp_b[4];

    initial begin
        exp_p = '{1'b0, 1'b1, 1'b1, 1'b0};
        exp_b = '{1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        chk_all("rst", 32'd0);
        chk("rst.print", 64'(o_print), 64'd0);
        chk("rst.busy",  64'(o_busy),  64'd0);
        chk("rst.w_dw",  64'(w_dw_cnt), 64'd0);

        // Instruction counters
        ir = 1; repeat (5) step(); ir = 0;
        ih = 1; repeat (3) step(); ih = 0;
        im = 1; repeat (2) step(); im = 0;
        chk("t1.ins_reads", 64'(o_ir), 64'd5);
        chk("t1.ins_hit",   64'(o_ih), 64'd3);
        chk("t1.ins_miss",  64'(o_im), 64'd2);
        chk("t1.data_reads", 64'(o_dr), 64'd0);
        chk("t1.data_hit",  64'(o_dh), 64'd0);
        chk("t1.print",     64'(o_print), 64'd0);

        // All strobes together, then a print request
        reset = 1; step(); reset = 0;
        {ir, ih, im, dr, dw, dh, dm} = '1;
        repeat (4) step();
        {ir, ih, im, dr, dw, dh, dm} = '0;
        chk_all("t2", 32'd4);
        preq = 1; step(); preq = 0;
        chk("t2.arm.busy",  64'(o_busy),  64'd1);
        chk("t2.arm.print", 64'(o_print), 64'd0);
        dr = 1; step(); dr = 0;          // event during ARM reaches the printout
        chk("t2.p1.print", 64'(o_print), 64'd1);
        chk("t2.p1.busy",  64'(o_busy),  64'd1);
        chk("t2.p1.data_reads", 64'(o_dr), 64'd5);
        step();
        chk("t2.p2.print", 64'(o_print), 64'd1);
        step();
        chk("t2.end.print", 64'(o_print), 64'd0);
        chk("t2.end.busy",  64'(o_busy),  64'd0);

        // 4-bit saturation on the second instance
        w_dw = 1;
        repeat (14) step();
        chk("t3.w14", 64'(w_dw_cnt), 64'd14);
        step();
        chk("t3.w15", 64'(w_dw_cnt), 64'd15);
        repeat (5) step();
        w_dw = 0;
        chk("t3.hold", 64'(w_dw_cnt), 64'd15);

        // PRINT_WIDTH=1 window on the second instance
        w_req = 1; step(); w_req = 0;
        chk("t3b.arm.busy", 64'(w_busy), 64'd1);
        chk("t3b.arm.print", 64'(w_print), 64'd0);
        step();
        chk("t3b.p1.print", 64'(w_print), 64'd1);
        step();
        chk("t3b.end.print", 64'(w_print), 64'd0);
        chk("t3b.end.busy",  64'(w_busy),  64'd0);

        // Clear beats a same-cycle strobe
        reset = 1; step(); reset = 0;
        dh = 1; repeat (7) step();
        chk("t4.pre", 64'(o_dh), 64'd7);
        clr = 1; step(); clr = 0;
        chk("t4.clr", 64'(o_dh), 64'd0);
        step(); dh = 0;
        chk("t4.after", 64'(o_dh), 64'd1);

        // print_req held for 12 cycles
        preq = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("t5.print[%0d]", i), 64'(o_print), 64'(exp_p[i % 4]));
            chk($sformatf("t5.busy[%0d]", i),  64'(o_busy),  64'(exp_b[i % 4]));
        end
        preq = 0;
        step();
        chk("t5.idle.busy", 64'(o_busy), 64'd0);

        // Reset during the second PRINT cycle, then a clean restart
        ir = 1; repeat (3) step(); ir = 0;
        preq = 1; step(); preq = 0;
        step();
        step();
        chk("t6.p2.print", 64'(o_print), 64'd1);
        reset = 1; step(); reset = 0;
        chk("t6.rst.print", 64'(o_print), 64'd0);
        chk("t6.rst.busy",  64'(o_busy),  64'd0);
        chk("t6.rst.ins_reads", 64'(o_ir), 64'd0);
        chk("t6.rst.data_hit",  64'(o_dh), 64'd0);
        preq = 1; step(); preq = 0;
        chk("t6.arm.busy",  64'(o_busy),  64'd1);
        chk("t6.arm.print", 64'(o_print), 64'd0);
        step();
        chk("t6.p1.print", 64'(o_print), 64'd1);
        step();
        chk("t6.p2b.print", 64'(o_print), 64'd1);
        step();
        chk("t6.end.print", 64'(o_print), 64'd0);
        chk("t6.end.busy",  64'(o_busy),  64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cache_stat_counters
